// File: rtl/mem_access_unit.sv
// Load/store front end: byte..word accesses onto a word-wide ROM/RAM port,
// splitting word-crossing accesses and returning one response per request.
module mem_access_unit #(
  parameter int SELECT_WIDTH = 8,
  parameter logic [SELECT_WIDTH-1:0] ROM_SELECT = SELECT_WIDTH'(8'h00),
  parameter logic [SELECT_WIDTH-1:0] RAM_SELECT = SELECT_WIDTH'(8'h01),
  parameter int MEM_ADDR_WIDTH = 8,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_signed,
  input  logic [1:0]                req_width,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic                      resp_fault,
  output logic [31:0]               resp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic                      mem_sel,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic [31:0]               mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RDLAST
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SELECT_WIDTH-1:0]   sel;
  logic [1:0]                off;
  logic [MEM_ADDR_WIDTH-1:0] w0;
  logic [2:0]                span;
  logic                      is_rom;
  logic                      is_ram;
  logic                      split;
  logic                      fault;
  logic                      accept;
  logic [3:0]                lanes;
  logic [7:0]                mask;
  logic [63:0]               shdata;
  logic                      unused_addr;

  logic                      q_write;
  logic                      q_signed;
  logic [1:0]                q_width;
  logic [1:0]                q_off;
  logic                      q_split;
  logic                      q_ram;
  logic [MEM_ADDR_WIDTH-1:0] q_w0;
  logic [7:0]                q_mask;
  logic [63:0]               q_data;
  logic [31:0]               word0_q;

  logic                      wr_done;
  logic [63:0]               words;
  logic [31:0]               shifted;
  logic                      sign;
  logic [31:0]               rdata_nx;

  assign sel    = req_addr[31 -: SELECT_WIDTH];
  assign off    = req_addr[1:0];
  assign w0     = req_addr[MEM_ADDR_WIDTH+1:2];
  assign span   = {1'b0, off} + {1'b0, req_width};
  assign split  = span > 3'd3;
  assign is_rom = sel == ROM_SELECT;
  assign is_ram = sel == RAM_SELECT;

  assign fault = !(is_rom || is_ram)
              || (req_write && is_rom)
              || (split && !ALLOW_MISALIGNED);

  assign req_ready = state == IDLE;
  assign accept    = req_valid && req_ready;

  assign lanes  = 4'((5'd2 << req_width) - 5'd1);
  assign mask   = {4'b0, lanes} << off;
  assign shdata = {32'b0, req_wdata} << {off, 3'b000};

  // Address bits between region select and word index are don't-care.
  assign unused_addr = ^req_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (accept && !fault) state_nx = ACC0;
      end
      ACC0: begin
        mem_en    = 1'b1;
        mem_we    = q_write;
        mem_sel   = q_ram;
        mem_addr  = q_w0;
        mem_wstrb = q_write ? q_mask[3:0] : 4'b0;
        mem_wdata = q_write ? q_data[31:0] : 32'b0;
        if (q_split)      state_nx = ACC1;
        else if (q_write) state_nx = IDLE;
        else              state_nx = RDLAST;
      end
      ACC1: begin
        mem_en    = 1'b1;
        mem_we    = q_write;
        mem_sel   = q_ram;
        mem_addr  = q_w0 + 1'b1;
        mem_wstrb = q_write ? q_mask[7:4] : 4'b0;
        mem_wdata = q_write ? q_data[63:32] : 32'b0;
        state_nx  = q_write ? IDLE : RDLAST;
      end
      RDLAST: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_write  <= 1'b0;
      q_signed <= 1'b0;
      q_width  <= '0;
      q_off    <= '0;
      q_split  <= 1'b0;
      q_ram    <= 1'b0;
      q_w0     <= '0;
      q_mask   <= '0;
      q_data   <= '0;
    end else if (accept) begin
      q_write  <= req_write;
      q_signed <= req_signed;
      q_width  <= req_width;
      q_off    <= off;
      q_split  <= split;
      q_ram    <= is_ram;
      q_w0     <= w0;
      q_mask   <= mask;
      q_data   <= shdata;
    end
  end

  // First word of a split read arrives while the second is being issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word0_q <= '0;
    end else if (state == ACC1 && !q_write) begin
      word0_q <= mem_rdata;
    end
  end

  assign wr_done = q_write
                && ((state == ACC0 && !q_split) || state == ACC1);

  always_comb begin
    words    = q_split ? {mem_rdata, word0_q} : {32'b0, mem_rdata};
    shifted  = 32'(words >> {q_off, 3'b000});
    sign     = q_signed & shifted[{q_width, 3'b111}];
    rdata_nx = '0;
    for (int i = 0; i < 4; i++) begin
      rdata_nx[8*i +: 8] = (2'(i) <= q_width) ? shifted[8*i +: 8]
                                              : {8{sign}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      if (accept && fault) begin
        resp_valid <= 1'b1;
        resp_fault <= 1'b1;
        resp_rdata <= '0;
      end
      if (wr_done) begin
        resp_valid <= 1'b1;
        resp_rdata <= '0;
      end
      if (state == RDLAST) begin
        resp_valid <= 1'b1;
        resp_rdata <= rdata_nx;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses and memory
// cycles are queued at issue and popped by negedge monitors.
module tb_mem_access_unit;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic        sel;
    logic [7:0]  addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          cyc;
  } mem_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_na = 1'b0;
  logic        req_write = 1'b0;
  logic        req_signed = 1'b0;
  logic [1:0]  req_width = 2'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we, mem_sel;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  logic        req_ready_na, resp_valid_na, resp_fault_na;
  logic [31:0] resp_rdata_na;
  logic        mem_en_na, mem_we_na, mem_sel_na;
  logic [7:0]  mem_addr_na;
  logic [31:0] mem_wdata_na;
  logic [3:0]  mem_wstrb_na;
  logic [31:0] mem_rdata_na = 32'h0;

  logic [31:0] ram [256];

  resp_t resp_q[$];
  mem_t  mem_q[$];
  resp_t rexp;
  mem_t  mexp;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_signed(req_signed),
    .req_width(req_width), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_fault(resp_fault),
    .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_na), .req_ready(req_ready_na),
    .req_write(req_write), .req_signed(req_signed),
    .req_width(req_width), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid_na), .resp_fault(resp_fault_na),
    .resp_rdata(resp_rdata_na),
    .mem_en(mem_en_na), .mem_we(mem_we_na), .mem_sel(mem_sel_na),
    .mem_addr(mem_addr_na), .mem_wdata(mem_wdata_na),
    .mem_wstrb(mem_wstrb_na), .mem_rdata(mem_rdata_na)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {8'hC0, a, ~a, 8'h5A};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One-cycle synchronous memory: ROM contents are a fixed pattern.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_wstrb);
      else
        mem_rdata <= mem_sel ? ram[mem_addr] : rom_word(mem_addr);
    end
  end

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  function automatic mem_t mrd(input logic s, input logic [7:0] a);
    mem_t m;
    m.we = 1'b0; m.sel = s; m.addr = a;
    m.strb = 4'h0; m.wdata = 32'h0; m.cyc = 0;
    return m;
  endfunction

  function automatic mem_t mwr(input logic s, input logic [7:0] a,
                               input logic [3:0] st,
                               input logic [31:0] d);
    mem_t m;
    m.we = 1'b1; m.sel = s; m.addr = a;
    m.strb = st; m.wdata = d; m.cyc = 0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (resp_valid) begin
      chk("resp_pending", 64'(resp_q.size() > 0), 64'd1);
      if (resp_q.size() > 0) begin
        rexp = resp_q.pop_front();
        chk("resp_fault", 64'(resp_fault), 64'(rexp.fault));
        chk("resp_rdata", 64'(resp_rdata), 64'(rexp.rdata));
        chk("resp_cycle", 64'(cyc), 64'(rexp.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      chk("mem_pending", 64'(mem_q.size() > 0), 64'd1);
      if (mem_q.size() > 0) begin
        mexp = mem_q.pop_front();
        chk("mem_we", 64'(mem_we), 64'(mexp.we));
        chk("mem_sel", 64'(mem_sel), 64'(mexp.sel));
        chk("mem_addr", 64'(mem_addr), 64'(mexp.addr));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(mexp.strb));
        chk("mem_wdata", 64'(mem_wdata), 64'(mexp.wdata));
        chk("mem_cycle", 64'(cyc), 64'(mexp.cyc));
      end
    end
    if (mem_en_na)
      chk("na_mem_en", 64'(mem_en_na), 64'd0);
  end

  task automatic issue(input logic w_, input logic s_,
                       input logic [1:0] wd, input logic [31:0] a,
                       input logic [31:0] d, input int nops,
                       input mem_t op0, input mem_t op1,
                       input bit has_resp, input logic ef,
                       input logic [31:0] er, input int lat);
    int t;
    int acc;
    resp_t r;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_write  = w_;
    req_signed = s_;
    req_width  = wd;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    if (nops > 0) begin
      op0.cyc = acc;
      mem_q.push_back(op0);
    end
    if (nops > 1) begin
      op1.cyc = acc + 1;
      mem_q.push_back(op1);
    end
    if (has_resp) begin
      r.fault = ef;
      r.rdata = er;
      r.cyc   = acc + lat - 1;
      resp_q.push_back(r);
    end
  endtask

  task automatic st(input logic [1:0] wd, input logic [31:0] a,
                    input logic [31:0] d, input int nops,
                    input mem_t op0, input mem_t op1, input int lat);
    issue(1'b1, 1'b0, wd, a, d, nops, op0, op1, 1'b1, 1'b0, 32'h0, lat);
  endtask

  task automatic ld(input logic s_, input logic [1:0] wd,
                    input logic [31:0] a, input int nops,
                    input mem_t op0, input mem_t op1, input int lat,
                    input logic [31:0] er);
    issue(1'b0, s_, wd, a, 32'h0, nops, op0, op1, 1'b1, 1'b0, er, lat);
  endtask

  task automatic flt(input logic w_, input logic [1:0] wd,
                     input logic [31:0] a);
    mem_t n;
    n = mrd(1'b0, 8'h00);
    issue(w_, 1'b0, wd, a, 32'h0BAD0BAD, 0, n, n, 1'b1, 1'b1, 32'h0, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((resp_q.size() != 0 || !req_ready) && t < 50);
    chk("drain", 64'(resp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem_t n;
    n = mrd(1'b0, 8'h00);

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_ready_na", 64'(req_ready_na), 64'd1);

    st(2'd3, 32'h0100_0008, 32'hDEADBEEF, 1,
       mwr(1, 8'h02, 4'hF, 32'hDEADBEEF), n, 2);
    ld(1'b1, 2'd0, 32'h0100_000B, 1, mrd(1, 8'h02), n, 3, 32'hFFFFFFDE);
    ld(1'b0, 2'd0, 32'h0100_000B, 1, mrd(1, 8'h02), n, 3, 32'h000000DE);

    st(2'd3, 32'h0100_0006, 32'h11223344, 2,
       mwr(1, 8'h01, 4'hC, 32'h33440000),
       mwr(1, 8'h02, 4'h3, 32'h00001122), 3);
    ld(1'b0, 2'd3, 32'h0100_0008, 1, mrd(1, 8'h02), n, 3, 32'hDEAD1122);

    st(2'd3, 32'h0100_0004, 32'hAB000000, 1,
       mwr(1, 8'h01, 4'hF, 32'hAB000000), n, 2);
    st(2'd3, 32'h0100_0008, 32'h000000CD, 1,
       mwr(1, 8'h02, 4'hF, 32'h000000CD), n, 2);
    ld(1'b1, 2'd1, 32'h0100_0007, 2, mrd(1, 8'h01), mrd(1, 8'h02),
       4, 32'hFFFFCDAB);
    ld(1'b0, 2'd2, 32'h0100_0006, 2, mrd(1, 8'h01), mrd(1, 8'h02),
       4, 32'h00CDAB00);

    st(2'd3, 32'h0100_000C, 32'h12803456, 1,
       mwr(1, 8'h03, 4'hF, 32'h12803456), n, 2);
    ld(1'b1, 2'd2, 32'h0100_000C, 1, mrd(1, 8'h03), n, 3, 32'hFF803456);
    ld(1'b0, 2'd1, 32'h0100_000E, 1, mrd(1, 8'h03), n, 3, 32'h00001280);
    ld(1'b1, 2'd1, 32'h0100_000D, 1, mrd(1, 8'h03), n, 3, 32'hFFFF8034);

    st(2'd0, 32'h0100_0011, 32'hFFFFFFA5, 1,
       mwr(1, 8'h04, 4'h2, 32'hFFFFA500), n, 2);
    st(2'd1, 32'h0100_0012, 32'h00001234, 1,
       mwr(1, 8'h04, 4'hC, 32'h12340000), n, 2);
    ld(1'b0, 2'd1, 32'h0100_0011, 1, mrd(1, 8'h04), n, 3, 32'h000034A5);

    ld(1'b0, 2'd3, 32'h0000_0004, 1, mrd(0, 8'h01), n, 3, 32'hC001FE5A);
    ld(1'b1, 2'd0, 32'h0000_0005, 1, mrd(0, 8'h01), n, 3, 32'hFFFFFFFE);

    flt(1'b1, 2'd3, 32'h0000_0010);
    flt(1'b0, 2'd3, 32'h0200_0000);
    flt(1'b1, 2'd0, 32'hFF00_0003);
    ld(1'b0, 2'd0, 32'h0100_0008, 1, mrd(1, 8'h02), n, 3, 32'h000000CD);

    wait_idle();
    @(negedge clk);
    chk("na_ready", 64'(req_ready_na), 64'd1);
    req_valid_na = 1'b1;
    req_write    = 1'b0;
    req_signed   = 1'b0;
    req_width    = 2'd3;
    req_addr     = 32'h0100_0001;
    @(posedge clk);
    #1;
    req_valid_na = 1'b0;
    @(negedge clk);
    chk("na_resp_valid", 64'(resp_valid_na), 64'd1);
    chk("na_resp_fault", 64'(resp_fault_na), 64'd1);
    chk("na_resp_rdata", 64'(resp_rdata_na), 64'd0);

    st(2'd3, 32'h0100_03FC, 32'h55667788, 1,
       mwr(1, 8'hFF, 4'hF, 32'h55667788), n, 2);
    st(2'd3, 32'h0100_0000, 32'h99AABBCC, 1,
       mwr(1, 8'h00, 4'hF, 32'h99AABBCC), n, 2);
    ld(1'b0, 2'd3, 32'h0100_03FE, 2, mrd(1, 8'hFF), mrd(1, 8'h00),
       4, 32'hBBCC5566);

    wait_idle();
    issue(1'b1, 1'b0, 2'd3, 32'h0100_000A, 32'hA1B2C3D4, 2,
          mwr(1, 8'h02, 4'hC, 32'hC3D40000),
          mwr(1, 8'h03, 4'h3, 32'h0000A1B2), 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("acc1_mem_en", 64'(mem_en), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_mem_en", 64'(mem_en), 64'd0);
    chk("arst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_rdata", 64'(resp_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_mem_en", 64'(mem_en), 64'd0);
    ld(1'b0, 2'd3, 32'h0100_0008, 1, mrd(1, 8'h02), n, 3, 32'hC3D400CD);
    ld(1'b0, 2'd3, 32'h0100_000C, 1, mrd(1, 8'h03), n, 3, 32'h12803456);

    wait_idle();
    chk("mem_q_empty", 64'(mem_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
